// File: rtl/uart_tx_arb_pkg.sv
// Shared definitions for the UART TX arbiter: FSM encoding and parameter defaults.
package uart_tx_arb_pkg;

  // One-hot encoding, matching the style of the UART TX state machine.
  typedef enum logic [3:0] {
    ST_IDLE      = 4'b0001,
    ST_ISSUE     = 4'b0010,
    ST_WAIT_BUSY = 4'b0100,
    ST_WAIT_DONE = 4'b1000
  } arb_state_t;

  localparam int NUM_REQ_DEFAULT    = 4;
  localparam int DATA_WIDTH_DEFAULT = 8;
  localparam int BUSY_TO_DEFAULT    = 15;

endpackage

// File: rtl/uart_tx_arb_if.sv
// Requester bus plus the byte/start/busy handshake toward the UART transmitter.
interface uart_tx_arb_if
  import uart_tx_arb_pkg::*;
#(
  parameter int NUM_REQ    = NUM_REQ_DEFAULT,
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_par_en;
  logic [NUM_REQ-1:0]            req_ack;
  logic [DATA_WIDTH-1:0]         tx_p_data;
  logic                          tx_par_en;
  logic                          tx_data_valid;
  logic                          tx_busy;

  // master: the arbiter; slave: the requesters and the UART TX around it
  modport master (
    input  req_valid, req_data, req_par_en, tx_busy,
    output req_ack, tx_p_data, tx_par_en, tx_data_valid
  );

  modport slave (
    output req_valid, req_data, req_par_en, tx_busy,
    input  req_ack, tx_p_data, tx_par_en, tx_data_valid
  );
endinterface

// File: rtl/uart_tx_arb_rr_pick.sv
// Cyclic priority encoder: first set request searching upward from ptr+1, wrapping.
module uart_tx_arb_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   grant,
  output logic               found
);
  logic [IDX_W-1:0]   cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0] cand_hit;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      assign cand_idx[gi] = IDX_W'((int'(ptr) + 1 + gi) % NUM_REQ);
      assign cand_hit[gi] = req_valid[cand_idx[gi]];
    end
  endgenerate

  // Scan from the far end so the nearest candidate overwrites the rest.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (cand_hit[k]) begin
        grant = cand_idx[k];
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte requesters.
module uart_tx_arb
  import uart_tx_arb_pkg::*;
#(
  parameter int NUM_REQ    = NUM_REQ_DEFAULT,
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int BUSY_TO    = BUSY_TO_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  uart_tx_arb_if.master              bus,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       arb_busy,
  output logic                       err_timeout
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(BUSY_TO + 1);

  arb_state_t            state_reg, state_next;
  logic [IDX_W-1:0]      ptr_reg, ptr_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic [NUM_REQ-1:0]    ack_reg, ack_next;
  logic [DATA_WIDTH-1:0] data_reg, data_next;
  logic                  par_reg, par_next;
  logic                  dv_reg, dv_next;
  logic                  busy_reg, busy_next;
  logic                  err_reg, err_next;
  logic [IDX_W-1:0]      pick_grant;
  logic                  pick_found;

  uart_tx_arb_rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req_valid (bus.req_valid),
    .ptr       (ptr_reg),
    .grant     (pick_grant),
    .found     (pick_found)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      ptr_reg   <= IDX_W'(NUM_REQ - 1);
      cnt_reg   <= '0;
      ack_reg   <= '0;
      data_reg  <= '0;
      par_reg   <= 1'b0;
      dv_reg    <= 1'b0;
      busy_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      cnt_reg   <= cnt_next;
      ack_reg   <= ack_next;
      data_reg  <= data_next;
      par_reg   <= par_next;
      dv_reg    <= dv_next;
      busy_reg  <= busy_next;
      err_reg   <= err_next;
    end
  end

  // Payload and parity enable are held between grants so the TX parity input stays stable.
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    cnt_next   = cnt_reg;
    ack_next   = '0;
    data_next  = data_reg;
    par_next   = par_reg;
    dv_next    = 1'b0;
    err_next   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (pick_found) begin
          data_next  = bus.req_data[pick_grant*DATA_WIDTH +: DATA_WIDTH];
          par_next   = bus.req_par_en[pick_grant];
          dv_next    = 1'b1;
          ack_next   = NUM_REQ'(1) << pick_grant;
          ptr_next   = pick_grant;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_next   = '0;
        state_next = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (bus.tx_busy) begin
          state_next = ST_WAIT_DONE;
        end else if (cnt_reg == CNT_W'(BUSY_TO - 1)) begin
          err_next   = 1'b1;
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (!bus.tx_busy) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    busy_next = (state_next != ST_IDLE);
  end

  assign bus.req_ack       = ack_reg;
  assign bus.tx_p_data     = data_reg;
  assign bus.tx_par_en     = par_reg;
  assign bus.tx_data_valid = dv_reg;
  assign grant_id          = ptr_reg;
  assign arb_busy          = busy_reg;
  assign err_timeout       = err_reg;
endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb with a behavioural UART TX (1 clock per bit, even parity).
module tb_uart_tx_arb;
  localparam int NR = 4;
  localparam int DW = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] grant_id;
  logic       arb_busy;
  logic       err_timeout;
  int         vec_cnt = 0;
  int         err_cnt = 0;

  always #5 clk = ~clk;

  uart_tx_arb_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

  uart_tx_arb #(.NUM_REQ(NR), .DATA_WIDTH(DW), .BUSY_TO(15)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .grant_id    (grant_id),
    .arb_busy    (arb_busy),
    .err_timeout (err_timeout)
  );

  // Behavioural transmitter: start state after the valid edge, then registered busy.
  logic        tx_mute = 1'b0;
  logic        tx_line;
  logic        tx_start;
  logic [10:0] fr;
  int          fr_len;
  int          fr_idx;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.tx_busy <= 1'b0;
      tx_line     <= 1'b1;
      tx_start    <= 1'b0;
      fr_idx      <= 0;
      fr_len      <= 0;
      fr          <= '0;
    end else begin
      tx_start <= bus.tx_data_valid && !tx_mute;
      if (bus.tx_data_valid && !tx_mute) begin
        if (bus.tx_par_en) begin
          fr     <= {1'b1, ^bus.tx_p_data, bus.tx_p_data, 1'b0};
          fr_len <= 11;
        end else begin
          fr     <= {2'b01, bus.tx_p_data, 1'b0};
          fr_len <= 10;
        end
      end
      if (tx_start) begin
        bus.tx_busy <= 1'b1;
        tx_line     <= fr[0];
        fr_idx      <= 1;
      end else if (bus.tx_busy) begin
        if (fr_idx < fr_len) begin
          tx_line <= fr[fr_idx];
          fr_idx  <= fr_idx + 1;
        end else begin
          bus.tx_busy <= 1'b0;
          tx_line     <= 1'b1;
        end
      end
    end
  end

  bit   mon_en = 1'b0;
  logic prev_dv = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      prev_dv = 1'b0;
    end else if (mon_en) begin
      vec_cnt++;
      if (bus.tx_data_valid && bus.tx_busy) begin
        err_cnt++;
        $display("FAIL proto_dv_while_busy got dv=1 busy=1 required dv=0");
      end
      vec_cnt++;
      if (bus.tx_data_valid && prev_dv) begin
        err_cnt++;
        $display("FAIL proto_dv_consecutive got two cycles high required one");
      end
      vec_cnt++;
      if (!$onehot0(bus.req_ack)) begin
        err_cnt++;
        $display("FAIL proto_ack_onehot got %b required one-hot or zero", bus.req_ack);
      end
      prev_dv = bus.tx_data_valid;
    end
  end

  bit   cap_en = 1'b0;
  logic cap_q[$];

  always @(negedge clk) if (cap_en && bus.tx_busy) cap_q.push_back(tx_line);

  task automatic wait_ack(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.req_ack != '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!arb_busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bus.req_valid  = '0;
    bus.req_data   = '0;
    bus.req_par_en = '0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    vec_cnt += 7;
    if (bus.req_ack !== 4'b0000) begin err_cnt++; $display("FAIL rst_ack got %b required 0000", bus.req_ack); end
    if (bus.tx_p_data !== 8'h00) begin err_cnt++; $display("FAIL rst_data got %h required 00", bus.tx_p_data); end
    if (bus.tx_par_en !== 1'b0) begin err_cnt++; $display("FAIL rst_par got %b required 0", bus.tx_par_en); end
    if (bus.tx_data_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_dv got %b required 0", bus.tx_data_valid); end
    if (grant_id !== 2'd3) begin err_cnt++; $display("FAIL rst_grant got %0d required 3", grant_id); end
    if (arb_busy !== 1'b0) begin err_cnt++; $display("FAIL rst_arb_busy got %b required 0", arb_busy); end
    if (err_timeout !== 1'b0) begin err_cnt++; $display("FAIL rst_err got %b required 0", err_timeout); end
    $display("reset: outputs checked");
    rst = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic test_single();
    bit seen_hi = 1'b0;
    bit fell = 1'b0;
    @(negedge clk);
    bus.req_valid  = 4'b0100;
    bus.req_data   = {8'h00, 8'hA5, 8'h00, 8'h00};
    bus.req_par_en = 4'b0100;
    @(negedge clk);
    vec_cnt += 6;
    if (bus.req_ack !== 4'b0100) begin err_cnt++; $display("FAIL single_ack got %b required 0100", bus.req_ack); end
    if (bus.tx_data_valid !== 1'b1) begin err_cnt++; $display("FAIL single_dv got %b required 1", bus.tx_data_valid); end
    if (bus.tx_p_data !== 8'hA5) begin err_cnt++; $display("FAIL single_data got %h required a5", bus.tx_p_data); end
    if (bus.tx_par_en !== 1'b1) begin err_cnt++; $display("FAIL single_par got %b required 1", bus.tx_par_en); end
    if (grant_id !== 2'd2) begin err_cnt++; $display("FAIL single_grant got %0d required 2", grant_id); end
    if (arb_busy !== 1'b1) begin err_cnt++; $display("FAIL single_arb_busy got %b required 1", arb_busy); end
    $display("single: grant=%0d data=%h par=%b", grant_id, bus.tx_p_data, bus.tx_par_en);
    bus.req_valid = '0;
    @(negedge clk);
    vec_cnt += 2;
    if (bus.req_ack !== 4'b0000 || bus.tx_data_valid !== 1'b0) begin
      err_cnt++; $display("FAIL single_pulse got ack=%b dv=%b required 0000/0", bus.req_ack, bus.tx_data_valid);
    end
    if (bus.tx_p_data !== 8'hA5) begin err_cnt++; $display("FAIL single_hold got %h required a5", bus.tx_p_data); end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.tx_busy) seen_hi = 1'b1;
      else if (seen_hi) begin fell = 1'b1; break; end
    end
    vec_cnt += 3;
    if (!fell) begin err_cnt++; $display("FAIL single_busy_fall got no fall required fall"); end
    if (arb_busy !== 1'b1) begin err_cnt++; $display("FAIL single_wait_done got arb_busy=%b required 1", arb_busy); end
    @(negedge clk);
    if (arb_busy !== 1'b0) begin err_cnt++; $display("FAIL single_idle got arb_busy=%b required 0", arb_busy); end
  endtask

  task automatic test_round_robin();
    int  exp_order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    bit  ok;
    time t_prev = 0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    bus.req_valid  = 4'b1111;
    bus.req_data   = {8'h13, 8'h12, 8'h11, 8'h10};
    bus.req_par_en = 4'b0000;
    for (int f = 0; f < 8; f++) begin
      wait_ack(ok);
      vec_cnt += 4;
      if (!ok) begin err_cnt++; $display("FAIL rr_ack_timeout frame %0d got none required ack", f); end
      if (bus.req_ack !== 4'(1 << exp_order[f])) begin
        err_cnt++; $display("FAIL rr_ack frame %0d got %b required bit %0d", f, bus.req_ack, exp_order[f]);
      end
      if (grant_id !== 2'(exp_order[f])) begin
        err_cnt++; $display("FAIL rr_grant frame %0d got %0d required %0d", f, grant_id, exp_order[f]);
      end
      if (bus.tx_p_data !== 8'(8'h10 + exp_order[f])) begin
        err_cnt++; $display("FAIL rr_data frame %0d got %h required %h", f, bus.tx_p_data, 8'(8'h10 + exp_order[f]));
      end
      if (f > 0) begin
        vec_cnt++;
        if ($time - t_prev != 140) begin
          err_cnt++; $display("FAIL rr_spacing frame %0d got %0t required 140", f, $time - t_prev);
        end
      end
      $display("rr: frame=%0d grant=%0d data=%h", f, grant_id, bus.tx_p_data);
      t_prev = $time;
      if (f == 7) bus.req_valid = '0;
      @(negedge clk);
      vec_cnt++;
      if (bus.req_ack !== 4'b0000) begin err_cnt++; $display("FAIL rr_ack_width frame %0d got %b required 0000", f, bus.req_ack); end
    end
    wait_idle(ok);
    vec_cnt++;
    if (!ok) begin err_cnt++; $display("FAIL rr_idle got busy required idle"); end
  endtask

  task automatic test_fairness();
    bit ok;
    bus.req_valid = 4'b0001;
    bus.req_data  = {8'h77, 8'h00, 8'h00, 8'h5A};
    wait_ack(ok);
    vec_cnt++;
    if (!ok || bus.req_ack !== 4'b0001) begin err_cnt++; $display("FAIL fair_prime got %b required 0001", bus.req_ack); end
    bus.req_valid = '0;
    wait_idle(ok);
    bus.req_valid = 4'b1001;
    wait_ack(ok);
    vec_cnt += 2;
    if (!ok || bus.req_ack !== 4'b1000) begin err_cnt++; $display("FAIL fair_skip_ack got %b required 1000", bus.req_ack); end
    if (bus.tx_p_data !== 8'h77) begin err_cnt++; $display("FAIL fair_skip_data got %h required 77", bus.tx_p_data); end
    $display("fair: grant=%0d data=%h", grant_id, bus.tx_p_data);
    bus.req_valid = 4'b0001;
    wait_ack(ok);
    vec_cnt += 2;
    if (!ok || bus.req_ack !== 4'b0001) begin err_cnt++; $display("FAIL fair_wrap_ack got %b required 0001", bus.req_ack); end
    if (grant_id !== 2'd0) begin err_cnt++; $display("FAIL fair_wrap_grant got %0d required 0", grant_id); end
    $display("fair: grant=%0d data=%h", grant_id, bus.tx_p_data);
    bus.req_valid = '0;
    wait_idle(ok);
    vec_cnt++;
    if (!ok) begin err_cnt++; $display("FAIL fair_idle got busy required idle"); end
  endtask

  task automatic test_timeout();
    bit ok;
    int first = -1;
    int pulses = 0;
    tx_mute = 1'b1;
    bus.req_valid = 4'b0010;
    bus.req_data  = {8'h00, 8'h00, 8'hE1, 8'h00};
    wait_ack(ok);
    vec_cnt++;
    if (!ok || bus.req_ack !== 4'b0010) begin err_cnt++; $display("FAIL to_ack got %b required 0010", bus.req_ack); end
    bus.req_valid = '0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (err_timeout) begin
        pulses++;
        if (first < 0) begin
          first = k;
          vec_cnt++;
          if (arb_busy !== 1'b0) begin err_cnt++; $display("FAIL to_state got arb_busy=%b required 0", arb_busy); end
        end
      end
    end
    vec_cnt += 2;
    if (first != 16) begin err_cnt++; $display("FAIL to_when got cycle %0d required 16", first); end
    if (pulses != 1) begin err_cnt++; $display("FAIL to_count got %0d pulses required 1", pulses); end
    $display("timeout: pulse at cycle %0d count %0d", first, pulses);
    tx_mute = 1'b0;
    bus.req_valid = 4'b0100;
    bus.req_data  = {8'h00, 8'h42, 8'h00, 8'h00};
    wait_ack(ok);
    vec_cnt += 2;
    if (!ok || bus.req_ack !== 4'b0100) begin err_cnt++; $display("FAIL to_recover_ack got %b required 0100", bus.req_ack); end
    if (bus.tx_p_data !== 8'h42) begin err_cnt++; $display("FAIL to_recover_data got %h required 42", bus.tx_p_data); end
    bus.req_valid = '0;
    wait_idle(ok);
    vec_cnt++;
    if (!ok) begin err_cnt++; $display("FAIL to_recover_idle got busy required idle"); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit hi = 1'b0;
    bus.req_valid  = 4'b1000;
    bus.req_data   = {8'h99, 8'h00, 8'h00, 8'h01};
    bus.req_par_en = 4'b1000;
    wait_ack(ok);
    bus.req_valid = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.tx_busy) begin hi = 1'b1; break; end
    end
    @(negedge clk);
    vec_cnt++;
    if (!hi || arb_busy !== 1'b1) begin err_cnt++; $display("FAIL mid_setup got busy=%b arb_busy=%b required 1/1", hi, arb_busy); end
    #2 rst = 1'b0;
    #1;
    vec_cnt += 7;
    if (bus.req_ack !== 4'b0000) begin err_cnt++; $display("FAIL mid_ack got %b required 0000", bus.req_ack); end
    if (bus.tx_p_data !== 8'h00) begin err_cnt++; $display("FAIL mid_data got %h required 00", bus.tx_p_data); end
    if (bus.tx_par_en !== 1'b0) begin err_cnt++; $display("FAIL mid_par got %b required 0", bus.tx_par_en); end
    if (bus.tx_data_valid !== 1'b0) begin err_cnt++; $display("FAIL mid_dv got %b required 0", bus.tx_data_valid); end
    if (grant_id !== 2'd3) begin err_cnt++; $display("FAIL mid_grant got %0d required 3", grant_id); end
    if (arb_busy !== 1'b0) begin err_cnt++; $display("FAIL mid_arb_busy got %b required 0", arb_busy); end
    if (err_timeout !== 1'b0) begin err_cnt++; $display("FAIL mid_err got %b required 0", err_timeout); end
    $display("reset_mid: outputs checked while reset held");
    @(negedge clk);
    rst = 1'b1;
    bus.req_valid = 4'b1001;
    wait_ack(ok);
    vec_cnt += 2;
    if (!ok || bus.req_ack !== 4'b0001) begin err_cnt++; $display("FAIL mid_prio_ack got %b required 0001", bus.req_ack); end
    if (bus.tx_p_data !== 8'h01) begin err_cnt++; $display("FAIL mid_prio_data got %h required 01", bus.tx_p_data); end
    $display("reset_mid: grant=%0d data=%h", grant_id, bus.tx_p_data);
    bus.req_valid = 4'b1000;
    wait_ack(ok);
    vec_cnt++;
    if (!ok || grant_id !== 2'd3) begin err_cnt++; $display("FAIL mid_next_grant got %0d required 3", grant_id); end
    $display("reset_mid: grant=%0d data=%h", grant_id, bus.tx_p_data);
    bus.req_valid = '0;
    wait_idle(ok);
  endtask

  task automatic test_uart();
    bit   ok;
    logic exp_line [21] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
                            1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    cap_q.delete();
    cap_en = 1'b1;
    bus.req_valid  = 4'b0011;
    bus.req_data   = {8'h00, 8'h00, 8'hC3, 8'h3C};
    bus.req_par_en = 4'b0001;
    wait_ack(ok);
    vec_cnt++;
    if (!ok || bus.req_ack !== 4'b0001 || bus.tx_p_data !== 8'h3C || bus.tx_par_en !== 1'b1) begin
      err_cnt++; $display("FAIL uart_f1 got ack=%b data=%h par=%b required 0001/3c/1", bus.req_ack, bus.tx_p_data, bus.tx_par_en);
    end
    $display("uart: grant=%0d data=%h par=%b", grant_id, bus.tx_p_data, bus.tx_par_en);
    bus.req_valid = 4'b0010;
    wait_ack(ok);
    vec_cnt++;
    if (!ok || bus.req_ack !== 4'b0010 || bus.tx_p_data !== 8'hC3 || bus.tx_par_en !== 1'b0) begin
      err_cnt++; $display("FAIL uart_f2 got ack=%b data=%h par=%b required 0010/c3/0", bus.req_ack, bus.tx_p_data, bus.tx_par_en);
    end
    $display("uart: grant=%0d data=%h par=%b", grant_id, bus.tx_p_data, bus.tx_par_en);
    bus.req_valid = '0;
    wait_idle(ok);
    cap_en = 1'b0;
    vec_cnt++;
    if (cap_q.size() != 21) begin
      err_cnt++; $display("FAIL uart_len got %0d bits required 21", cap_q.size());
    end else begin
      for (int i = 0; i < 21; i++) begin
        vec_cnt++;
        if (cap_q[i] !== exp_line[i]) begin
          err_cnt++; $display("FAIL uart_bit %0d got %b required %b", i, cap_q[i], exp_line[i]);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got no finish required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_fairness();
    test_timeout();
    test_reset_mid();
    test_uart();
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/uart_tx_arb.md
Name: uart_tx_arb

Overview:
- Round-robin arbiter and sequencer that shares one UART transmitter (serializer, parity, mux and TX FSM) between NUM_REQ byte requesters.
- Picks one requester at a time and captures its byte and parity-enable setting.
- Issues a single-cycle data_valid to the transmitter, then holds off further grants until the transmitter's busy flag has risen and fallen again.
- Sits between the producer blocks and the UART TX top.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 8, frame payload width.
- BUSY_TO, 15, max cycles to wait for tx_busy to rise after issue before flagging an error.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester byte pending.
- req_data  in  NUM_REQ*DATA_WIDTH  flattened payloads; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_par_en  in  NUM_REQ  per-requester parity enable.
- req_ack  out  NUM_REQ  one-hot single-cycle accept pulse.
- tx_p_data  out  DATA_WIDTH  byte to UART TX.
- tx_par_en  out  1  PAR_EN to UART TX.
- tx_data_valid  out  1  single-cycle start pulse to UART TX.
- tx_busy  in  1  registered busy flag from UART TX.
- grant_id  out  $clog2(NUM_REQ)  index of the last granted requester.
- arb_busy  out  1  high whenever the state is not IDLE.
- err_timeout  out  1  single-cycle pulse when BUSY_TO expires.

Behaviour:
- Reset (rst=0, asynchronous) forces the following, including mid-frame:
  - req_ack=0, tx_p_data=0, tx_par_en=0, tx_data_valid=0, grant_id=NUM_REQ-1, arb_busy=0, err_timeout=0.
  - Timeout counter=0, state=IDLE, round-robin pointer=NUM_REQ-1, so requester 0 has first priority.
- All outputs are registered. No combinational path from any input to any output.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - If any req_valid is set, grant g = first set bit searching cyclically from pointer+1.
  - On that edge: tx_p_data<=req_data[g], tx_par_en<=req_par_en[g], tx_data_valid<=1, req_ack<=onehot(g), grant_id<=g, pointer<=g, state<=ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (exactly 1 cycle):
  - tx_data_valid and req_ack are high this cycle only; both clear on the next edge.
  - Next state: WAIT_BUSY with counter=0.
- WAIT_BUSY:
  - tx_busy=1 -> WAIT_DONE.
  - Otherwise increment counter. When counter reaches BUSY_TO-1 without busy: err_timeout<=1 for one cycle, state<=IDLE.
  - Nominal rise is 2 cycles after the issue edge (TX start state, then registered busy).
- WAIT_DONE:
  - tx_busy=0 -> IDLE. The next grant can occur no earlier than the following edge.
  - No timeout in this state.
- Grant-to-grant minimum: ISSUE + WAIT_BUSY(>=1) + WAIT_DONE(>=1) + IDLE.
- tx_data_valid is never asserted while tx_busy=1. This guarantees the TX stop-to-start back-to-back path is never used.
- Requester contract:
  - Hold req_valid and req_data stable until req_ack is seen.
  - Data is sampled on the grant edge.
  - Drop or advance req_valid in the cycle after req_ack. A req_valid still high during ISSUE is ignored.
- Fairness: the just-granted requester has lowest priority in the next arbitration. With all requesters pending, grants go 0,1,2,3,0,...
- Wrap-around: a pointer at NUM_REQ-1 searches from 0.
- tx_p_data and tx_par_en hold their values after ISSUE until the next grant, keeping the parity calculator input stable for the whole frame.
- A req_valid change while arb_busy=1 has no effect until IDLE.

Decomposition:
- Shared package: state encodings (one-hot, 4 bits, same style as the TX FSM) and the BUSY_TO default.
- One natural sub-module: rr_pick. Combinational cyclic priority encoder, inputs req_valid and pointer, outputs grant index and found flag. Reusable by a future RX/TX scheduler.

Test Plan:
- Single request: reset, req_valid=4'b0100, data[2]=8'hA5, par_en[2]=1.
  - One edge later: req_ack=4'b0100, tx_data_valid=1, tx_p_data=8'hA5, tx_par_en=1, grant_id=2.
  - Model busy high 2 cycles after issue for 11 cycles, then low. Arbiter returns to IDLE 1 cycle after busy falls.
- All four requesters held valid for 8 frames: grant order 0,1,2,3,0,1,2,3. Exactly one req_ack per frame.
- Fairness skip: valid=4'b1001 with last grant 0 -> next grant 3, then 0.
- Timeout: issue with tx_busy held 0 -> err_timeout pulses exactly once, BUSY_TO cycles after entering WAIT_BUSY. State returns to IDLE and the next request is served normally.
- Reset mid-frame: assert rst during WAIT_DONE -> all outputs return to their reset values immediately (asynchronously). After release, requester 0 wins over requester 3 when both are valid.
- Protocol assertions across all runs:
  - tx_data_valid is never high while tx_busy=1, and is never high on two consecutive cycles.
  - req_ack is always one-hot or zero.
  - Integrated with the real UART TX: 8'h3C with parity on, then 8'hC3 with parity off; the serial line carries the correct two frames.
